voice_allocator: RTL and testbench

//  Turns MIDI note-on/off events into parameter-RAM writes for the voice controller.
//  - Finds a voice slot for each note.
//  - Looks up delta_phase from an external note-to-phase ROM.
//  - Writes the parameter entry only inside the update window that voice_controller grants.
//  - Sits between the MIDI decoder (event FIFO side) and the parameter RAM write port.

---
 rtl/voice_allocator.sv | 229 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Maps MIDI note-on/off events onto voice slots and issues one
//               parameter-RAM write per event inside the controller's window.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 256,
    parameter int VOICE_AW   = 8,
    parameter int PARAM_W    = 37
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ev_valid,
    output logic                ev_ready,
    input  logic                ev_note_on,
    input  logic [6:0]          ev_note,
    input  logic [3:0]          ev_wave,
    output logic [6:0]          lut_addr,
    input  logic [31:0]         lut_data,
    output logic                update_req,
    input  logic                update_grant,
    output logic                param_we,
    output logic [VOICE_AW-1:0] param_addr,
    output logic [PARAM_W-1:0]  param_data,
    output logic                busy,
    output logic                stolen,
    output logic                dropped
);

    localparam logic [VOICE_AW-1:0] c_LAST = VOICE_AW'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_LUT     = 3'd2,
        S_LUT_CAP = 3'd3,
        S_REQ     = 3'd4,
        S_WRITE   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    // latched event
    logic                r_on;
    logic [6:0]          r_note;
    logic [3:0]          r_wave;

    // scan bookkeeping
    logic [VOICE_AW-1:0] r_idx;
    logic [VOICE_AW-1:0] r_slot;
    logic                r_have_match;
    logic [VOICE_AW-1:0] r_match_slot;
    logic                r_have_free;
    logic [VOICE_AW-1:0] r_free_slot;

    logic [VOICE_AW-1:0] r_target;
    logic                r_retrig;
    logic [31:0]         r_lut_data;
    logic [VOICE_AW-1:0] r_rr_ptr;
    logic                r_stolen;
    logic                r_dropped;

    logic                r_active [NUM_VOICES];
    logic [6:0]          r_vnote  [NUM_VOICES];

    logic                w_hit;
    logic                w_empty;
    logic                w_last;
    logic                w_any_match;
    logic                w_any_free;
    logic [VOICE_AW-1:0] w_match_slot;
    logic [VOICE_AW-1:0] w_free_slot;
    logic [VOICE_AW-1:0] w_slot_next;
    logic [VOICE_AW-1:0] w_rr_next;
    logic [36:0]         w_word;

    // The slot under examination this cycle is folded in so the decision at
    // the last scan cycle already sees all NUM_VOICES slots.
    always_comb begin
        w_hit        = r_active[r_slot] && (r_vnote[r_slot] == r_note);
        w_empty      = !r_active[r_slot];
        w_last       = (r_idx == c_LAST);
        w_any_match  = r_have_match || w_hit;
        w_any_free   = r_have_free || w_empty;
        w_match_slot = r_have_match ? r_match_slot : r_slot;
        w_free_slot  = r_have_free  ? r_free_slot  : r_slot;
        w_slot_next  = (r_slot   == c_LAST) ? '0 : r_slot   + 1'b1;
        w_rr_next    = (r_rr_ptr == c_LAST) ? '0 : r_rr_ptr + 1'b1;
        w_word       = {1'b1, r_wave, r_lut_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ev_valid) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    if (r_on) begin
                        w_next = S_LUT;
                    end else if (w_any_match) begin
                        w_next = S_REQ;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_LUT:     w_next = S_LUT_CAP;
            S_LUT_CAP: w_next = S_REQ;
            S_REQ: begin
                if (update_grant) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ev_ready   = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        update_req = (r_state == S_REQ);
        param_we   = (r_state == S_WRITE);
        lut_addr   = (r_state == S_LUT) ? r_note : 7'd0;
        param_addr = (r_state == S_WRITE) ? r_target : '0;
        param_data = ((r_state == S_WRITE) && r_on) ? PARAM_W'(w_word) : '0;
        stolen     = r_stolen;
        dropped    = r_dropped;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_on         <= 1'b0;
            r_note       <= '0;
            r_wave       <= '0;
            r_idx        <= '0;
            r_slot       <= '0;
            r_have_match <= 1'b0;
            r_match_slot <= '0;
            r_have_free  <= 1'b0;
            r_free_slot  <= '0;
            r_target     <= '0;
            r_retrig     <= 1'b0;
            r_lut_data   <= '0;
            r_rr_ptr     <= '0;
            r_stolen     <= 1'b0;
            r_dropped    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_active[v] <= 1'b0;
                r_vnote[v]  <= '0;
            end
        end else begin
            r_stolen  <= 1'b0;
            r_dropped <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ev_valid) begin
                        r_on         <= ev_note_on;
                        r_note       <= ev_note;
                        r_wave       <= ev_wave;
                        r_idx        <= '0;
                        r_slot       <= r_rr_ptr;
                        r_have_match <= 1'b0;
                        r_have_free  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_hit && !r_have_match) begin
                        r_have_match <= 1'b1;
                        r_match_slot <= r_slot;
                    end
                    if (w_empty && !r_have_free) begin
                        r_have_free <= 1'b1;
                        r_free_slot <= r_slot;
                    end
                    r_idx  <= r_idx + 1'b1;
                    r_slot <= w_slot_next;
                    if (w_last) begin
                        if (w_any_match) begin
                            r_target <= w_match_slot;
                            r_retrig <= 1'b1;
                        end else if (w_any_free) begin
                            r_target <= w_free_slot;
                            r_retrig <= 1'b0;
                        end else begin
                            r_target <= r_rr_ptr;
                            r_retrig <= 1'b0;
                        end
                        r_stolen  <= r_on && !w_any_match && !w_any_free;
                        r_dropped <= !r_on && !w_any_match;
                    end
                end
                S_LUT_CAP: begin
                    r_lut_data <= lut_data;
                end
                S_WRITE: begin
                    if (r_on) begin
                        r_active[r_target] <= 1'b1;
                        r_vnote[r_target]  <= r_note;
                        if (!r_retrig) begin
                            r_rr_ptr <= w_rr_next;
                        end
                    end else begin
                        r_active[r_target] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Randomized and directed checks of voice_allocator against a
//               slot-search reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int AW = 2;
    localparam int PW = 37;

    logic          clk = 1'b0;
    logic          reset;
    logic          ev_valid;
    logic          ev_ready;
    logic          ev_note_on;
    logic [6:0]    ev_note;
    logic [3:0]    ev_wave;
    logic [6:0]    lut_addr;
    logic [31:0]   lut_data;
    logic          update_req;
    logic          update_grant;
    logic          param_we;
    logic [AW-1:0] param_addr;
    logic [PW-1:0] param_data;
    logic          busy;
    logic          stolen;
    logic          dropped;

    voice_allocator #(
        .NUM_VOICES (NV),
        .VOICE_AW   (AW),
        .PARAM_W    (PW)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_note_on   (ev_note_on),
        .ev_note      (ev_note),
        .ev_wave      (ev_wave),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .update_req   (update_req),
        .update_grant (update_grant),
        .param_we     (param_we),
        .param_addr   (param_addr),
        .param_data   (param_data),
        .busy         (busy),
        .stolen       (stolen),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    // synchronous note-to-phase ROM
    always @(posedge clk) lut_data <= {25'b0, lut_addr};

    int n_total  = 0;
    int n_bad    = 0;
    int we_count = 0;

    always @(negedge clk) if (param_we === 1'b1) we_count++;

    // reference model state
    bit m_active [NV];
    int m_note   [NV];
    int m_rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 1'b0;
            m_note[i]   = 0;
        end
        m_rr = 0;
    endtask

    task automatic model_event(input bit on, input logic [6:0] note, input logic [3:0] wave,
                               output bit w, output int addr, output logic [PW-1:0] data,
                               output bit st, output bit dr);
        int match;
        int free;
        int s;
        match = -1;
        free  = -1;
        for (int k = 0; k < NV; k++) begin
            s = (m_rr + k) % NV;
            if (match < 0 && m_active[s] && m_note[s] == int'(note)) match = s;
            if (free < 0 && !m_active[s]) free = s;
        end
        st = 1'b0; dr = 1'b0; w = 1'b1; data = '0; addr = 0;
        if (on) begin
            data = {1'b1, wave, 25'b0, note};
            if (match >= 0) begin
                addr = match;
            end else begin
                if (free >= 0) addr = free;
                else begin
                    addr = m_rr;
                    st   = 1'b1;
                end
                m_rr = (m_rr + 1) % NV;
            end
            m_active[addr] = 1'b1;
            m_note[addr]   = int'(note);
        end else if (match >= 0) begin
            addr = match;
            m_active[addr] = 1'b0;
        end else begin
            w  = 1'b0;
            dr = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        ev_valid     = 1'b0;
        update_grant = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_event(input bit on, input logic [6:0] note, input logic [3:0] wave,
                             input int gdelay, input bit spur);
        bit            e_write, e_st, e_dr, seen_st, seen_dr, done, hold_ok;
        int            e_addr, c, we0, waited;
        logic [PW-1:0] e_data;
        model_event(on, note, wave, e_write, e_addr, e_data, e_st, e_dr);
        waited = 0;
        while (ev_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_ready", ev_ready, 1);
        we0        = we_count;
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = note;
        ev_wave    = wave;
        tick();
        ev_valid = 1'b0;
        c = 1; seen_st = 1'b0; seen_dr = 1'b0; done = 1'b0;
        while (!done && c < NV + 12) begin
            seen_st |= (stolen === 1'b1);
            seen_dr |= (dropped === 1'b1);
            if (update_req === 1'b1 || ev_ready === 1'b1) done = 1'b1;
            else begin
                update_grant = (spur && c == 2);
                tick();
                update_grant = 1'b0;
                c++;
            end
        end
        if (e_write) check(on ? "req_lat_on" : "req_lat_off", c, on ? NV + 3 : NV + 1);
        else         check("drop_ready_lat", c, NV + 1);
        check("stolen", seen_st, e_st);
        check("dropped", seen_dr, e_dr);
        if (e_write && update_req === 1'b1) begin
            hold_ok = 1'b1;
            for (int g = 0; g < gdelay; g++) begin
                tick();
                if (update_req !== 1'b1 || param_we !== 1'b0) hold_ok = 1'b0;
            end
            check("req_hold", hold_ok, 1);
            update_grant = 1'b1;
            tick();
            update_grant = 1'b0;
            check("param_we", param_we, 1);
            check("req_fall", update_req, 0);
            check("param_addr", param_addr, e_addr);
            check("param_data", param_data, e_data);
            tick();
            check("we_single", param_we, 0);
            check("ready_after", ev_ready, 1);
        end
        tick();
        check("we_count", we_count - we0, e_write ? 1 : 0);
    endtask

    initial begin
        bit   r_on_b;
        int   waited, we0;
        ev_note_on   = 1'b0;
        ev_note      = '0;
        ev_wave      = '0;
        reset        = 1'b1;
        ev_valid     = 1'b0;
        update_grant = 1'b0;
        tick();
        tick();
        check("rst_ready", ev_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", update_req, 0);
        check("rst_we", param_we, 0);
        check("rst_flags", {stolen, dropped}, 0);
        check("rst_outs", {lut_addr, param_addr, param_data}, 0);
        reset = 1'b0;
        model_reset();

        // single note-on, grant 3 cycles after request
        run_event(1'b1, 7'd60, 4'd2, 3, 1'b0);

        // fill all slots then steal; then release the stolen slot's new note
        do_reset();
        run_event(1'b1, 7'd60, 4'd1, 0, 1'b0);
        run_event(1'b1, 7'd62, 4'd1, 1, 1'b0);
        run_event(1'b1, 7'd64, 4'd1, 2, 1'b0);
        run_event(1'b1, 7'd65, 4'd1, 0, 1'b0);
        run_event(1'b1, 7'd67, 4'd3, 1, 1'b0);
        run_event(1'b0, 7'd67, 4'd0, 0, 1'b0);

        // retrigger, next allocation, release, duplicate release
        do_reset();
        run_event(1'b1, 7'd60, 4'd5, 0, 1'b0);
        run_event(1'b1, 7'd60, 4'd6, 0, 1'b0);
        run_event(1'b1, 7'd61, 4'd6, 0, 1'b0);
        run_event(1'b0, 7'd60, 4'd0, 2, 1'b0);
        run_event(1'b0, 7'd60, 4'd0, 0, 1'b0);

        // note-off with nothing active
        do_reset();
        run_event(1'b0, 7'd70, 4'd0, 0, 1'b0);

        // grants outside REQ are ignored
        update_grant = 1'b1;
        tick();
        update_grant = 1'b0;
        run_event(1'b1, 7'd72, 4'd9, 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r_on_b = ($urandom_range(0, 2) != 0);
            run_event(r_on_b, 7'(60 + $urandom_range(0, 5)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // reset while waiting for a grant
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = 7'd80;
        ev_wave    = 4'd4;
        tick();
        ev_valid = 1'b0;
        we0      = we_count;
        waited   = 0;
        while (update_req !== 1'b1 && waited < NV + 12) begin
            tick();
            waited++;
        end
        check("abort_reached_req", update_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("abort_req", update_req, 0);
        check("abort_ready", ev_ready, 1);
        check("abort_busy", busy, 0);
        tick();
        tick();
        check("abort_no_we", we_count - we0, 0);
        run_event(1'b1, 7'd81, 4'd7, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
